segmentation_processor: RTL and testbench
=========================================

# segmentation_processor

Per-pixel semantic segmentation engine for small RGB frames. It reads an interleaved 8-bit RGB image from an external synchronous input memory and smooths each pixel over a 3x3 neighbourhood. It classifies each pixel by colour dominance and writes an 8-bit class map to an external output memory. It sits between the frame buffer and the downstream label consumer, and is controlled by a start/done handshake.

## Interface
- INPUT_WIDTH, 16: frame width in pixels (≥ 2).
- INPUT_HEIGHT, 16: frame height in pixels (≥ 2).
- INPUT_CHANNELS, 3: channels per pixel; only 3 is supported, in R,G,B order.
- NUM_CLASSES, 21: number of labels; must be ≥ 2. Class values are clamped to NUM_CLASSES-1.
- SPREAD_THRESH, 96: colour-spread threshold, in per-pixel average units.
- clk  in  1  single clock; all logic is on the rising edge.
- rst  in  1  reset; synchronous and active-low (0 = reset).
- start  in  1  one-cycle or level request; sampled only in IDLE and DONE.
- busy  out  1  high while a frame is being processed.
- done  out  1  high from frame completion until the next accepted start or reset.
- in_rd_en  out  1  input memory read strobe.
- in_addr  out  $clog2(W*H*3)  input byte address, computed as (y*W+x)*3+c.
- in_data  in  8  read data; valid exactly 1 cycle after in_rd_en/in_addr.
- out_we  out  1  output memory write strobe.
- out_addr  out  $clog2(W*H)  output address, computed as y*W+x.
- out_data  out  8  class label.

## Operation
- States: IDLE, READ, DRAIN, CLASSIFY, WRITE, DONE.
- IDLE or DONE with start=1 → READ. This clears done, sets busy, and sets the pixel counters to (x,y)=(0,0).
- READ (27 cycles): issues one read per cycle for neighbour rows dy=-1..1, then columns dx=-1..1, then channel c=0..2, with c fastest. Neighbour coordinates are clamped to [0,W-1] and [0,H-1] (edge replication).
- Each returning byte is added into an unsigned 12-bit channel sum S[c]. The maximum sum is 9*255=2295.
- READ → DRAIN (1 cycle): accumulates the last byte and issues no read.
- CLASSIFY (1 cycle):
  - max = largest S; dom = index of the first maximum (ties go to the lowest index: R over G over B); min = smallest S.
  - If max−min < 9*SPREAD_THRESH, class = 0 (achromatic/background).
  - Otherwise class = min(1+dom, NUM_CLASSES-1), so R→1, G→2, B→3.
- WRITE (1 cycle): out_we=1, out_addr=y*W+x, out_data=class. Sums are cleared and the pixel advances raster-order (x first).
  - If more pixels remain → READ.
  - After pixel (W-1,H-1) → DONE.
- DONE: busy=0, done=1; holds until an accepted start or reset.
- start while busy is ignored.
- Each output pixel is written exactly once per frame, in raster order. Input memory is never written.

## Timing
- Reset (rst=0 at a clock edge): state=IDLE. busy, done, in_rd_en and out_we are 0. in_addr, out_addr and out_data are 0. Sums and counters are 0.
- Reset asserted mid-frame aborts immediately: no further out_we, and partial output is left as written.
- start accepted at edge k: first in_rd_en is in cycle k+1.
- Each pixel takes 30 cycles: 27 READ, 1 DRAIN, 1 CLASSIFY, 1 WRITE.
- The last out_we is in cycle k+30*W*H. done and busy=0 are visible from cycle k+30*W*H+1. For 16x16 this is 7681 cycles after the start edge.
- out_we is a single-cycle pulse per pixel. in_rd_en is high only in READ.
- Outputs are registered; no combinational path from start or in_data to any output.

## Test plan
- Reset: drive rst=0 for 2 cycles with start toggling → all outputs 0, state IDLE; after release, done stays 0 until start.
- Gray/background frame, 16x16, every channel = 0x20+((x+y)&0x1F) → all 256 labels 0; done at start+7681 cycles; exactly 256 out_we pulses at addresses 0..255 in order.
- Centre square, 16x16: pixels x,y∈[4,11] are R=0xFF, G=B=0x40; the rest are the background above.
  - Square pixels except its 4 corners → label 1; corners (4,4), (4,11), (11,4), (11,11) → 0.
  - All pixels outside the square → 0.
- Solid colour frames: R=G=0, B=0xC0 → all labels 3; G=0xC0, others 0 → all 2. Equal R=G=0xC0, B=0 → all 1 (tie rule).
- NUM_CLASSES=2 with a solid blue frame → all labels clamped to 1.
- Control corners:
  - start pulsed mid-frame → ignored; timing is unchanged.
  - rst=0 at pixel 100 → out_we stops immediately and outputs return to reset values.
  - A new start from DONE → done drops next cycle and the frame reprocesses identically.

Source files
------------

// File: rtl/segmentation_processor_if.sv
// Handshake and memory-bus bundle for segmentation_processor.
// master = frame-buffer/controller side, slave = the segmentation engine.
interface segmentation_processor_if #(
  parameter int INPUT_WIDTH    = 16,
  parameter int INPUT_HEIGHT   = 16,
  parameter int INPUT_CHANNELS = 3
);
  localparam int IN_AW  = $clog2(INPUT_WIDTH * INPUT_HEIGHT * INPUT_CHANNELS);
  localparam int OUT_AW = $clog2(INPUT_WIDTH * INPUT_HEIGHT);

  logic              start;
  logic              busy;
  logic              done;
  logic              in_rd_en;
  logic [IN_AW-1:0]  in_addr;
  logic [7:0]        in_data;
  logic              out_we;
  logic [OUT_AW-1:0] out_addr;
  logic [7:0]        out_data;

  modport master (
    output start, in_data,
    input  busy, done, in_rd_en, in_addr, out_we, out_addr, out_data
  );

  modport slave (
    input  start, in_data,
    output busy, done, in_rd_en, in_addr, out_we, out_addr, out_data
  );
endinterface

// File: rtl/segmentation_processor.sv
// 3x3 box-sum RGB smoother and colour-dominance classifier; one label per pixel,
// 30 cycles per pixel, driven by a start/done handshake.
module segmentation_processor #(
  parameter int INPUT_WIDTH    = 16,
  parameter int INPUT_HEIGHT   = 16,
  parameter int INPUT_CHANNELS = 3,
  parameter int NUM_CLASSES    = 21,
  parameter int SPREAD_THRESH  = 96
) (
  input logic                     clk,
  input logic                     rst,
  segmentation_processor_if.slave bus
);
  localparam int W      = INPUT_WIDTH;
  localparam int H      = INPUT_HEIGHT;
  localparam int IN_AW  = $clog2(W * H * INPUT_CHANNELS);
  localparam int OUT_AW = $clog2(W * H);
  localparam int XW     = $clog2(W);
  localparam int YW     = $clog2(H);

  localparam logic [XW-1:0] X_LAST     = XW'(W - 1);
  localparam logic [YW-1:0] Y_LAST     = YW'(H - 1);
  localparam logic [15:0]   SPREAD_LIM = 16'(9 * SPREAD_THRESH);
  localparam logic [7:0]    CLASS_MAX  = 8'(NUM_CLASSES - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_READ     = 3'd1,
    S_DRAIN    = 3'd2,
    S_CLASSIFY = 3'd3,
    S_WRITE    = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t            state_r;
  logic [XW-1:0]     x_r;
  logic [YW-1:0]     y_r;
  logic [1:0]        ry_r;
  logic [1:0]        rx_r;
  logic [1:0]        rc_r;
  logic [11:0]       sum_r [3];
  logic              pend_r;
  logic [1:0]        pend_c_r;
  logic              busy_r;
  logic              done_r;
  logic              rd_en_r;
  logic              we_r;
  logic [IN_AW-1:0]  in_addr_r;
  logic [OUT_AW-1:0] out_addr_r;
  logic [7:0]        out_data_r;

  logic          last_rd_s;
  logic [1:0]    ry_nx_s;
  logic [1:0]    rx_nx_s;
  logic [1:0]    rc_nx_s;
  logic          last_px_s;
  logic [XW-1:0] x_nx_s;
  logic [YW-1:0] y_nx_s;
  logic [11:0]   max_s;
  logic [11:0]   min_s;
  logic [1:0]    dom_s;
  logic [15:0]   spread_s;
  logic [7:0]    cls_s;

  // Byte address of neighbour (px+dx-1, py+dy-1), channel ch, with edge replication.
  function automatic logic [IN_AW-1:0] rd_addr_f(
    input logic [XW-1:0] px,
    input logic [YW-1:0] py,
    input logic [1:0]    dy,
    input logic [1:0]    dx,
    input logic [1:0]    ch
  );
    int nx;
    int ny;
    nx = int'(px) + int'(dx) - 32'sd1;
    ny = int'(py) + int'(dy) - 32'sd1;
    nx = (nx < 32'sd0) ? 32'sd0 : ((nx > W - 1) ? W - 1 : nx);
    ny = (ny < 32'sd0) ? 32'sd0 : ((ny > H - 1) ? H - 1 : ny);
    return IN_AW'((ny * W + nx) * INPUT_CHANNELS + int'(ch));
  endfunction

  // Neighbourhood read sequencer: channel fastest, then column, then row.
  always_comb begin
    last_rd_s = (ry_r == 2'd2) && (rx_r == 2'd2) && (rc_r == 2'd2);
    ry_nx_s   = ry_r;
    rx_nx_s   = rx_r;
    rc_nx_s   = rc_r;
    if (rc_r == 2'd2) begin
      rc_nx_s = 2'd0;
      if (rx_r == 2'd2) begin
        rx_nx_s = 2'd0;
        ry_nx_s = ry_r + 2'd1;
      end else begin
        rx_nx_s = rx_r + 2'd1;
      end
    end else begin
      rc_nx_s = rc_r + 2'd1;
    end
  end

  // Raster-order pixel stepping.
  always_comb begin
    last_px_s = (x_r == X_LAST) && (y_r == Y_LAST);
    x_nx_s    = x_r;
    y_nx_s    = y_r;
    if (x_r == X_LAST) begin
      x_nx_s = '0;
      y_nx_s = y_r + YW'(1);
    end else begin
      x_nx_s = x_r + XW'(1);
    end
  end

  // Dominance classification; ties resolve towards the lower channel index.
  always_comb begin
    max_s = sum_r[0];
    dom_s = 2'd0;
    if ((sum_r[0] >= sum_r[1]) && (sum_r[0] >= sum_r[2])) begin
      max_s = sum_r[0];
      dom_s = 2'd0;
    end else if (sum_r[1] >= sum_r[2]) begin
      max_s = sum_r[1];
      dom_s = 2'd1;
    end else begin
      max_s = sum_r[2];
      dom_s = 2'd2;
    end
    min_s = sum_r[0];
    if ((sum_r[1] <= sum_r[0]) && (sum_r[1] <= sum_r[2])) begin
      min_s = sum_r[1];
    end else if ((sum_r[2] <= sum_r[0]) && (sum_r[2] <= sum_r[1])) begin
      min_s = sum_r[2];
    end else begin
      min_s = sum_r[0];
    end
    spread_s = {4'd0, max_s} - {4'd0, min_s};
    cls_s    = {6'd0, dom_s} + 8'd1;
    if (spread_s < SPREAD_LIM) begin
      cls_s = 8'd0;
    end else if (cls_s > CLASS_MAX) begin
      cls_s = CLASS_MAX;
    end else begin
      cls_s = {6'd0, dom_s} + 8'd1;
    end
  end

  // Control FSM, accumulators and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= S_IDLE;
      x_r        <= '0;
      y_r        <= '0;
      ry_r       <= 2'd0;
      rx_r       <= 2'd0;
      rc_r       <= 2'd0;
      sum_r[0]   <= 12'd0;
      sum_r[1]   <= 12'd0;
      sum_r[2]   <= 12'd0;
      pend_r     <= 1'b0;
      pend_c_r   <= 2'd0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      rd_en_r    <= 1'b0;
      we_r       <= 1'b0;
      in_addr_r  <= '0;
      out_addr_r <= '0;
      out_data_r <= 8'd0;
    end else begin
      // Read data returns one cycle after the strobe; remember which channel it was.
      pend_r   <= rd_en_r;
      pend_c_r <= rc_r;
      if (pend_r) begin
        sum_r[pend_c_r] <= sum_r[pend_c_r] + {4'd0, bus.in_data};
      end
      we_r <= 1'b0;
      case (state_r)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state_r   <= S_READ;
            busy_r    <= 1'b1;
            done_r    <= 1'b0;
            x_r       <= '0;
            y_r       <= '0;
            ry_r      <= 2'd0;
            rx_r      <= 2'd0;
            rc_r      <= 2'd0;
            sum_r[0]  <= 12'd0;
            sum_r[1]  <= 12'd0;
            sum_r[2]  <= 12'd0;
            rd_en_r   <= 1'b1;
            in_addr_r <= rd_addr_f('0, '0, 2'd0, 2'd0, 2'd0);
          end else begin
            state_r <= state_r;
          end
        end
        S_READ: begin
          if (last_rd_s) begin
            rd_en_r <= 1'b0;
            state_r <= S_DRAIN;
          end else begin
            ry_r      <= ry_nx_s;
            rx_r      <= rx_nx_s;
            rc_r      <= rc_nx_s;
            in_addr_r <= rd_addr_f(x_r, y_r, ry_nx_s, rx_nx_s, rc_nx_s);
          end
        end
        S_DRAIN: begin
          state_r <= S_CLASSIFY;
        end
        S_CLASSIFY: begin
          we_r       <= 1'b1;
          out_addr_r <= OUT_AW'(int'(y_r) * W + int'(x_r));
          out_data_r <= cls_s;
          state_r    <= S_WRITE;
        end
        S_WRITE: begin
          sum_r[0] <= 12'd0;
          sum_r[1] <= 12'd0;
          sum_r[2] <= 12'd0;
          if (last_px_s) begin
            state_r <= S_DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            x_r       <= x_nx_s;
            y_r       <= y_nx_s;
            ry_r      <= 2'd0;
            rx_r      <= 2'd0;
            rc_r      <= 2'd0;
            rd_en_r   <= 1'b1;
            in_addr_r <= rd_addr_f(x_nx_s, y_nx_s, 2'd0, 2'd0, 2'd0);
            state_r   <= S_READ;
          end
        end
        default: begin
          state_r <= S_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          rd_en_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.in_rd_en = rd_en_r;
  assign bus.in_addr  = in_addr_r;
  assign bus.out_we   = we_r;
  assign bus.out_addr = out_addr_r;
  assign bus.out_data = out_data_r;
endmodule

// File: tb/tb_segmentation_processor.sv
// Self-checking bench: three engine instances (16x16, 5x4, 3x2 with 2 classes)
// sharing one image store, checked against a plain-arithmetic reference.
module tb_segmentation_processor;
  localparam int SPREAD = 96;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  segmentation_processor_if #(.INPUT_WIDTH(16), .INPUT_HEIGHT(16), .INPUT_CHANNELS(3)) bus0 ();
  segmentation_processor_if #(.INPUT_WIDTH(5),  .INPUT_HEIGHT(4),  .INPUT_CHANNELS(3)) bus1 ();
  segmentation_processor_if #(.INPUT_WIDTH(3),  .INPUT_HEIGHT(2),  .INPUT_CHANNELS(3)) bus2 ();

  segmentation_processor #(.INPUT_WIDTH(16), .INPUT_HEIGHT(16), .INPUT_CHANNELS(3),
    .NUM_CLASSES(21), .SPREAD_THRESH(SPREAD)) u0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  segmentation_processor #(.INPUT_WIDTH(5), .INPUT_HEIGHT(4), .INPUT_CHANNELS(3),
    .NUM_CLASSES(21), .SPREAD_THRESH(SPREAD)) u1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  segmentation_processor #(.INPUT_WIDTH(3), .INPUT_HEIGHT(2), .INPUT_CHANNELS(3),
    .NUM_CLASSES(2), .SPREAD_THRESH(SPREAD)) u2 (.clk(clk), .rst(rst), .bus(bus2.slave));

  logic [7:0] img [0:767];
  logic [7:0] pal [0:191];
  int exp_lab [0:255];
  int ca0[$], cd0[$], ca1[$], cd1[$], ca2[$], cd2[$];
  int rd_cnt [3];
  int errors;
  int checks;

  typedef struct {
    int sel;
    int r;
    int g;
    int b;
    int exp;
  } solid_t;
  solid_t tbl [10];

  // Synchronous-read input memories: data one cycle after the strobe.
  always @(posedge clk) begin
    if (bus0.in_rd_en === 1'b1) bus0.in_data <= img[int'(bus0.in_addr)];
    if (bus1.in_rd_en === 1'b1) bus1.in_data <= img[int'(bus1.in_addr)];
    if (bus2.in_rd_en === 1'b1) bus2.in_data <= img[int'(bus2.in_addr)];
  end

  // Output-memory capture and read-strobe counting.
  always @(posedge clk) begin
    if (bus0.out_we === 1'b1) begin ca0.push_back(int'(bus0.out_addr)); cd0.push_back(int'(bus0.out_data)); end
    if (bus1.out_we === 1'b1) begin ca1.push_back(int'(bus1.out_addr)); cd1.push_back(int'(bus1.out_data)); end
    if (bus2.out_we === 1'b1) begin ca2.push_back(int'(bus2.out_addr)); cd2.push_back(int'(bus2.out_data)); end
    if (bus0.in_rd_en === 1'b1) rd_cnt[0]++;
    if (bus1.in_rd_en === 1'b1) rd_cnt[1]++;
    if (bus2.in_rd_en === 1'b1) rd_cnt[2]++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int dim_w(input int sel);
    case (sel) 0: return 16; 1: return 5; default: return 3; endcase
  endfunction
  function automatic int dim_h(input int sel);
    case (sel) 0: return 16; 1: return 4; default: return 2; endcase
  endfunction
  function automatic int dim_nc(input int sel);
    case (sel) 0: return 21; 1: return 21; default: return 2; endcase
  endfunction

  // {busy, done, in_rd_en, out_we}
  function automatic logic [3:0] status(input int sel);
    case (sel)
      0: return {bus0.busy, bus0.done, bus0.in_rd_en, bus0.out_we};
      1: return {bus1.busy, bus1.done, bus1.in_rd_en, bus1.out_we};
      default: return {bus2.busy, bus2.done, bus2.in_rd_en, bus2.out_we};
    endcase
  endfunction

  task automatic set_start(input int sel, input logic v);
    case (sel)
      0: bus0.start = v;
      1: bus1.start = v;
      default: bus2.start = v;
    endcase
  endtask

  function automatic int cap_size(input int sel);
    case (sel) 0: return ca0.size(); 1: return ca1.size(); default: return ca2.size(); endcase
  endfunction

  task automatic cap_get(input int sel, input int i, output int a, output int d);
    case (sel)
      0: begin a = ca0[i]; d = cd0[i]; end
      1: begin a = ca1[i]; d = cd1[i]; end
      default: begin a = ca2[i]; d = cd2[i]; end
    endcase
  endtask

  task automatic clear_cap(input int sel);
    case (sel)
      0: begin ca0.delete(); cd0.delete(); end
      1: begin ca1.delete(); cd1.delete(); end
      default: begin ca2.delete(); cd2.delete(); end
    endcase
    rd_cnt[sel] = 0;
  endtask

  // Reference: 3x3 channel sums with clamped coordinates, then dominance rule.
  function automatic int ref_label(input int w, input int h, input int nc, input int x, input int y);
    int s [3];
    int mx, mn, dom, lab;
    s[0] = 0; s[1] = 0; s[2] = 0;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++) begin
        int nx, ny;
        nx = x + dx; ny = y + dy;
        if (nx < 0) nx = 0;
        if (nx > w - 1) nx = w - 1;
        if (ny < 0) ny = 0;
        if (ny > h - 1) ny = h - 1;
        for (int c = 0; c < 3; c++) s[c] += int'(img[(ny * w + nx) * 3 + c]);
      end
    mx = s[0]; mn = s[0]; dom = 0;
    for (int c = 1; c < 3; c++) begin
      if (s[c] > mx) begin mx = s[c]; dom = c; end
      if (s[c] < mn) mn = s[c];
    end
    if (mx - mn < 9 * SPREAD) return 0;
    lab = 1 + dom;
    return (lab > nc - 1) ? nc - 1 : lab;
  endfunction

  task automatic fill_gray();
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++)
        for (int c = 0; c < 3; c++) img[(y * 16 + x) * 3 + c] = 8'(32'h20 + ((x + y) & 32'h1F));
  endtask

  task automatic fill_solid(input int r, input int g, input int b);
    for (int p = 0; p < 256; p++) begin
      img[p * 3 + 0] = 8'(r); img[p * 3 + 1] = 8'(g); img[p * 3 + 2] = 8'(b);
    end
  endtask

  // Random 2x2 blocks of quantised colours so that every class appears.
  task automatic fill_blocks(input int w, input int h);
    for (int i = 0; i < 192; i++) pal[i] = 8'($urandom_range(0, 3) * 85);
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++)
        for (int c = 0; c < 3; c++) img[(y * w + x) * 3 + c] = pal[((y / 2) * 8 + (x / 2)) * 3 + c];
  endtask

  task automatic fill_ref(input int sel);
    for (int y = 0; y < dim_h(sel); y++)
      for (int x = 0; x < dim_w(sel); x++)
        exp_lab[y * dim_w(sel) + x] = ref_label(dim_w(sel), dim_h(sel), dim_nc(sel), x, y);
  endtask

  task automatic check_reset0(input string tag);
    check({tag, "/busy"},     bus0.busy,     32'd0);
    check({tag, "/done"},     bus0.done,     32'd0);
    check({tag, "/in_rd_en"}, bus0.in_rd_en, 32'd0);
    check({tag, "/out_we"},   bus0.out_we,   32'd0);
    check({tag, "/in_addr"},  bus0.in_addr,  32'd0);
    check({tag, "/out_addr"}, bus0.out_addr, 32'd0);
    check({tag, "/out_data"}, bus0.out_data, 32'd0);
  endtask

  task automatic run_frame(input int sel, input string name, input bit mid_pulse);
    int np, n, last_we, a, d;
    logic [3:0] st;
    np = dim_w(sel) * dim_h(sel);
    clear_cap(sel);
    @(negedge clk); set_start(sel, 1'b1);
    @(posedge clk); #1; set_start(sel, 1'b0);
    st = status(sel);
    check({name, "/busy_at_start"}, st[3], 32'd1);
    check({name, "/done_dropped"},  st[2], 32'd0);
    check({name, "/first_rd_en"},   st[1], 32'd1);
    n = 0; last_we = -1;
    while (st[2] !== 1'b1 && n < 30 * np + 50) begin
      @(posedge clk); #1; n++;
      st = status(sel);
      if (st[0] === 1'b1) last_we = n;
      if (mid_pulse) set_start(sel, (n == 2) || (n == 1000));
    end
    check({name, "/done_latency"},  n,       30 * np);
    check({name, "/last_we_cycle"}, last_we, 30 * np - 1);
    check({name, "/busy_at_done"},  st[3],   32'd0);
    check({name, "/we_count"},      cap_size(sel), np);
    check({name, "/rd_count"},      rd_cnt[sel],   27 * np);
    for (int i = 0; i < cap_size(sel) && i < np; i++) begin
      cap_get(sel, i, a, d);
      check($sformatf("%s/addr%0d", name, i),  a, i);
      check($sformatf("%s/label%0d", name, i), d, exp_lab[i]);
    end
    repeat (3) @(posedge clk);
    #1;
    st = status(sel);
    check({name, "/done_holds"}, st[3:2], 32'd1);
  endtask

  initial begin
    int n;
    int a, d;
    errors = 0; checks = 0;
    tbl[0] = '{1, 32'h00, 32'h00, 32'hC0, 3};
    tbl[1] = '{1, 32'h00, 32'hC0, 32'h00, 2};
    tbl[2] = '{1, 32'hC0, 32'hC0, 32'h00, 1};
    tbl[3] = '{1, 32'h40, 32'h40, 32'h40, 0};
    tbl[4] = '{1, 32'hC0, 32'h00, 32'hC0, 1};
    tbl[5] = '{1, 32'h00, 32'hC0, 32'hC0, 2};
    tbl[6] = '{1, 32'h90, 32'h30, 32'h30, 1};
    tbl[7] = '{1, 32'h8F, 32'h30, 32'h30, 0};
    tbl[8] = '{2, 32'h00, 32'h00, 32'hC0, 1};
    tbl[9] = '{2, 32'h00, 32'hC0, 32'h00, 1};

    rst = 1'b0;
    bus0.start = 1'b0; bus1.start = 1'b0; bus2.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); bus0.start = (i == 0);
      @(posedge clk); #1;
      check_reset0($sformatf("reset%0d", i));
    end
    @(negedge clk); rst = 1'b1; bus0.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("idle_after_reset", status(0), 32'd0);

    fill_gray();
    for (int p = 0; p < 256; p++) exp_lab[p] = 0;
    run_frame(0, "gray", 1'b0);

    fill_gray();
    for (int y = 4; y <= 11; y++)
      for (int x = 4; x <= 11; x++) begin
        img[(y * 16 + x) * 3 + 0] = 8'hFF;
        img[(y * 16 + x) * 3 + 1] = 8'h40;
        img[(y * 16 + x) * 3 + 2] = 8'h40;
      end
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++)
        exp_lab[y * 16 + x] = (x >= 4 && x <= 11 && y >= 4 && y <= 11 &&
                               !((x == 4 || x == 11) && (y == 4 || y == 11))) ? 1 : 0;
    run_frame(0, "square_midstart", 1'b1);

    for (int t = 0; t < 10; t++) begin
      fill_solid(tbl[t].r, tbl[t].g, tbl[t].b);
      for (int p = 0; p < 256; p++) exp_lab[p] = tbl[t].exp;
      run_frame(tbl[t].sel, $sformatf("solid%0d", t), 1'b0);
    end

    fill_blocks(16, 16);
    fill_ref(0);
    run_frame(0, "rand16", 1'b0);
    run_frame(0, "rand16_rerun", 1'b0);
    for (int k = 0; k < 3; k++) begin
      fill_blocks(5, 4); fill_ref(1);
      run_frame(1, $sformatf("rand5x4_%0d", k), 1'b0);
    end
    for (int k = 0; k < 2; k++) begin
      fill_blocks(3, 2); fill_ref(2);
      run_frame(2, $sformatf("rand3x2nc2_%0d", k), 1'b0);
    end

    // Reset in the middle of pixel 100.
    fill_gray();
    clear_cap(0);
    @(negedge clk); bus0.start = 1'b1;
    @(posedge clk); #1; bus0.start = 1'b0;
    n = 0;
    while (n < 3015) begin @(posedge clk); #1; n++; end
    check("abort/writes_before", cap_size(0), 32'd100);
    @(negedge clk); rst = 1'b0; bus0.start = 1'b1;
    @(posedge clk); #1;
    check_reset0("abort");
    @(negedge clk); bus0.start = 1'b0;
    @(posedge clk); #1;
    check_reset0("abort_hold");
    @(negedge clk); rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("abort/idle_after", status(0), 32'd0);
    check("abort/writes_after", cap_size(0), 32'd100);
    for (int i = 0; i < cap_size(0); i++) begin
      cap_get(0, i, a, d);
      check($sformatf("abort/addr%0d", i), a, i);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
